// File: rtl/accel_pkg.sv
// accel_pkg: shared types and helpers for the digest UART sender.
package accel_pkg;

    typedef enum logic [1:0] {IDLE, SEND, DONE} sender_state_e;

    localparam int UART_FRAME_BITS = 10;

    function automatic int calc_clks_per_bit(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer; a start in the final stop-bit cycle chains frames gaplessly.
module uart_tx_byte
    import accel_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] BIT_LAST = 4'(UART_FRAME_BITS - 1);

    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          wrap;

    always_comb begin
        wrap   = busy_q && baud_q == BAUD_LAST;
        baud_d = (busy_q && !wrap) ? baud_q + 1'b1 : '0;
        bit_d  = bit_q;
        sh_d   = sh_q;
        tx_d   = tx_q;
        busy_d = busy_q;
        if (wrap) begin
            bit_d = bit_q + 1'b1;
            tx_d  = (bit_q < 4'd8) ? sh_q[0] : 1'b1;
            sh_d  = sh_q >> 1;
            if (bit_q == BIT_LAST) begin
                bit_d  = '0;
                busy_d = 1'b0;
            end
        end
        if (start_i) begin
            baud_d = '0;
            bit_d  = '0;
            sh_d   = data_i;
            tx_d   = 1'b0;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            baud_q <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            baud_q <= baud_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            tx_q   <= tx_d;
            busy_q <= busy_d;
        end
    end

    assign tx_o   = tx_q;
    assign done_o = wrap && bit_q == BIT_LAST;

endmodule

// File: rtl/digest_uart_sender.sv
// digest_uart_sender: latches the digest once per write phase and streams it MSB byte first over 8N1 UART.
module digest_uart_sender
    import accel_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int DIGEST_BITS = 256
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic                   write_enable,
    input  logic [DIGEST_BITS-1:0] digest_i,
    output logic                   uart_tx_o,
    output logic                   finished_sending,
    output logic                   busy_o
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int NUM_BYTES    = DIGEST_BITS / 8;
    localparam int IW           = $clog2(NUM_BYTES + 1);
    localparam logic [IW-1:0] LAST_BYTE = IW'(NUM_BYTES - 1);

    if (DIGEST_BITS % 8 != 0) begin : g_bad_digest
        $error("DIGEST_BITS must be a multiple of 8");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("CLKS_PER_BIT must be at least 2");
    end

    sender_state_e          state_q, state_d;
    logic [DIGEST_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0]          byte_q, byte_d;
    logic                   armed_q, armed_d;
    logic                   launch, tx_start, tx_done;
    logic [7:0]             tx_data;

    assign launch = state_q == IDLE && write_enable && armed_q;

    // shift_q holds the bytes still to be handed to the serializer, next one on top
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        armed_d  = armed_q | ~write_enable;
        tx_start = 1'b0;
        tx_data  = shift_q[DIGEST_BITS-1 -: 8];
        if (launch) begin
            state_d  = SEND;
            armed_d  = 1'b0;
            shift_d  = digest_i << 8;
            byte_d   = '0;
            tx_start = 1'b1;
            tx_data  = digest_i[DIGEST_BITS-1 -: 8];
        end else if (state_q == SEND && tx_done) begin
            if (byte_q == LAST_BYTE) begin
                state_d = DONE;
            end else begin
                byte_d   = byte_q + 1'b1;
                shift_d  = shift_q << 8;
                tx_start = 1'b1;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            byte_q  <= '0;
            armed_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            armed_q <= armed_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst_i  (rst_i),
        .start_i(tx_start),
        .data_i (tx_data),
        .tx_o   (uart_tx_o),
        .done_o (tx_done)
    );

    assign finished_sending = state_q == DONE;
    assign busy_o           = state_q == SEND;

endmodule
